anton_neopixel_multi: RTL and testbench

ANTON_NEOPIXEL_MULTI -- requirements
Module: anton_neopixel_multi

---
 rtl/anton_neopixel_multi.sv | 227 ++++++++++++++++++++++
 tb/tb_anton_neopixel_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_multi.sv
// anton_neopixel_multi: multi-channel NeoPixel serial streamer.
// Each channel owns a byte buffer. All channels shift out in lockstep,
// MSB first, then share a common latch (reset) low period.
module anton_neopixel_multi #(
    parameter int CHANNELS    = 4,
    parameter int BUFFER_END  = 255,
    parameter int RESET_DELAY = 385,
    parameter int T0H         = 3,
    parameter int T1H         = 6,
    parameter int TBIT        = 9
) (
    input  logic                clk7mhz,
    input  logic                resetn,
    input  logic [15:0]         busAddr,
    input  logic [7:0]          busDataIn,
    input  logic                busWrite,
    input  logic                busRead,
    output logic [7:0]          busDataOut,
    output logic [CHANNELS-1:0] neoData,
    output logic                neoState,
    output logic                pixelsSync,
    output logic                irq
);

    localparam int DEPTH = BUFFER_END + 1;
    localparam int OFFW  = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;
    localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0]     BEND  = 16'(BUFFER_END);
    localparam logic [15:0]     LDLY  = 16'(RESET_DELAY);
    localparam logic [15:0]     TLAST = 16'(TBIT - 1);
    localparam logic [OFFW-1:0] OFF0  = '0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TRANSMIT, S_LATCH} state_t;

    state_t              r_state, w_next;
    logic [7:0]          r_mem   [CHANNELS][DEPTH];
    logic [7:0]          r_shift [CHANNELS];
    logic [15:0]         r_cnt, r_off;
    logic [2:0]          r_bit;
    logic [12:0]         r_max;
    logic                r_limit, r_run, r_loop, r_b32, r_irq, r_abort;
    logic [CHANNELS-1:0] r_mask;
    logic [7:0]          r_dout;

    logic [14:0]     w_chan;
    logic [OFFW-1:0] w_boff;
    logic            w_buf_ok, w_regwr, w_init_wr, w_irqclr;
    logic [15:0]     w_max16, w_last, w_nxt1, w_nxt;
    logic            w_bit_end, w_byte_last, w_done, w_abort_go;
    logic [7:0]      w_rdata;

    assign w_chan    = busAddr[14:0] >> OFFW;
    assign w_boff    = busAddr[OFFW-1:0];
    assign w_buf_ok  = !busAddr[15] && (w_chan < 15'(CHANNELS)) && (16'(w_boff) <= BEND);
    assign w_regwr   = busWrite && busAddr[15];
    assign w_init_wr = w_regwr && (busAddr[14:0] == 15'd2) && busDataIn[0];
    assign w_irqclr  = w_regwr && (busAddr[14:0] == 15'd5) && busDataIn[0];

    // Last offset of the frame; in 32-bit mode offsets ending in 3 are skipped,
    // so the frame also ends when the next sendable offset lies past the limit.
    assign w_max16     = {3'b000, r_max};
    assign w_last      = (r_limit && (w_max16 < BEND)) ? w_max16 : BEND;
    assign w_nxt1      = r_off + 16'd1;
    assign w_nxt       = (r_b32 && (w_nxt1[1:0] == 2'b11)) ? (r_off + 16'd2) : w_nxt1;
    assign w_bit_end   = (r_cnt == TLAST);
    assign w_byte_last = (r_off >= w_last) || (w_nxt > w_last);

    assign neoState   = (r_state == S_LATCH);
    assign pixelsSync = (r_state == S_LATCH);
    assign irq        = r_irq;
    assign busDataOut = r_dout;

    // FSM state register
    always_ff @(posedge clk7mhz) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // FSM next state, frame-done/abort strobes and serial output levels
    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_abort_go = 1'b0;
        neoData    = '0;
        case (r_state)
            S_IDLE:     if (r_run) w_next = S_LOAD;
            S_LOAD: begin
                if (!r_run) begin
                    w_next     = S_LATCH;
                    w_abort_go = 1'b1;
                end else begin
                    w_next = S_TRANSMIT;
                end
            end
            S_TRANSMIT: begin
                for (int unsigned c = 0; c < CHANNELS; c++)
                    neoData[c] = r_mask[c] &&
                                 (r_cnt < (r_shift[c][7] ? 16'(T1H) : 16'(T0H)));
                if (!r_run) begin
                    w_next     = S_LATCH;
                    w_abort_go = 1'b1;
                    neoData    = '0;
                end else if (w_bit_end && (r_bit == 3'd7) && w_byte_last) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_cnt == LDLY) begin
                    if (r_loop && r_run) begin
                        w_next = S_LOAD;
                    end else begin
                        w_next = S_IDLE;
                        w_done = !r_abort;
                    end
                end
            end
            default:    w_next = S_IDLE;
        endcase
        if (w_init_wr) w_next = S_IDLE;
    end

    // Tick/bit/offset counters and per-channel shift registers
    always_ff @(posedge clk7mhz) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_off   <= '0;
            r_bit   <= '0;
            r_abort <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) r_shift[c] <= '0;
        end else begin
            if ((w_next != r_state) || (r_state == S_IDLE) ||
                ((r_state == S_TRANSMIT) && w_bit_end))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;

            if (w_abort_go)
                r_abort <= 1'b1;
            else if ((w_next == S_IDLE) || (w_next == S_LOAD))
                r_abort <= 1'b0;

            case (r_state)
                S_LOAD: begin
                    r_off <= '0;
                    r_bit <= '0;
                    for (int unsigned c = 0; c < CHANNELS; c++) r_shift[c] <= r_mem[c][OFF0];
                end
                S_TRANSMIT: begin
                    if (w_bit_end) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            // Fetch on the last tick of the last bit: no gap, and
                            // writes up to this point are still picked up.
                            r_off <= w_nxt;
                            for (int unsigned c = 0; c < CHANNELS; c++)
                                r_shift[c] <= r_mem[c][w_nxt[OFFW-1:0]];
                        end else begin
                            for (int unsigned c = 0; c < CHANNELS; c++)
                                r_shift[c] <= {r_shift[c][6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control/status registers; a bus CTRL write overrides the FSM run clear
    always_ff @(posedge clk7mhz) begin
        if (!resetn) begin
            r_max   <= '0;
            r_limit <= 1'b0;
            r_run   <= 1'b0;
            r_loop  <= 1'b0;
            r_b32   <= 1'b0;
            r_mask  <= '1;
            r_irq   <= 1'b0;
        end else begin
            if (w_done) r_run <= 1'b0;
            if (w_regwr) begin
                case (busAddr[14:0])
                    15'd0: r_max[7:0]  <= busDataIn;
                    15'd1: r_max[12:8] <= busDataIn[4:0];
                    15'd2: begin
                        r_limit <= busDataIn[1] && !busDataIn[0];
                        r_run   <= busDataIn[2] && !busDataIn[0];
                        r_loop  <= busDataIn[3] && !busDataIn[0];
                        r_b32   <= busDataIn[4] && !busDataIn[0];
                    end
                    15'd4: r_mask <= busDataIn[CHANNELS-1:0];
                    default: ;
                endcase
            end
            if (w_done)        r_irq <= 1'b1;
            else if (w_irqclr) r_irq <= 1'b0;
        end
    end

    // Channel buffers (not cleared by reset)
    always_ff @(posedge clk7mhz) begin
        if (busWrite && w_buf_ok) r_mem[w_chan[CHW-1:0]][w_boff] <= busDataIn;
    end

    // Read data selection
    always_comb begin
        w_rdata = '0;
        if (busAddr[15]) begin
            case (busAddr[14:0])
                15'd0:   w_rdata = r_max[7:0];
                15'd1:   w_rdata = {3'b000, r_max[12:8]};
                15'd2:   w_rdata = {3'b000, r_b32, r_loop, r_run, r_limit, 1'b0};
                15'd3:   w_rdata = {5'b00000, r_irq, (r_state != S_IDLE), (r_state == S_LATCH)};
                15'd4:   w_rdata = 8'(r_mask);
                default: w_rdata = '0;
            endcase
        end else if (w_buf_ok) begin
            w_rdata = r_mem[w_chan[CHW-1:0]][w_boff];
        end
    end

    // Registered read data, one cycle after busRead
    always_ff @(posedge clk7mhz) begin
        if (!resetn)      r_dout <= '0;
        else if (busRead) r_dout <= w_rdata;
    end

endmodule

// File: tb/tb_anton_neopixel_multi.sv
// Directed bench for anton_neopixel_multi (default parameters).
module tb_anton_neopixel_multi;

    logic        clk7mhz = 1'b0;
    logic        resetn  = 1'b0;
    logic [15:0] busAddr = '0;
    logic [7:0]  busDataIn = '0;
    logic        busWrite = 1'b0;
    logic        busRead  = 1'b0;
    logic [7:0]  busDataOut;
    logic [3:0]  neoData;
    logic        neoState, pixelsSync, irq;

    int checks = 0;
    int errors = 0;
    logic [3:0] cap [4096];

    always #5 clk7mhz = ~clk7mhz;

    anton_neopixel_multi #(
        .CHANNELS(4), .BUFFER_END(255), .RESET_DELAY(385),
        .T0H(3), .T1H(6), .TBIT(9)
    ) dut (
        .clk7mhz(clk7mhz), .resetn(resetn), .busAddr(busAddr),
        .busDataIn(busDataIn), .busWrite(busWrite), .busRead(busRead),
        .busDataOut(busDataOut), .neoData(neoData), .neoState(neoState),
        .pixelsSync(pixelsSync), .irq(irq)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk7mhz);
        busAddr = a; busDataIn = d; busWrite = 1'b1;
        @(negedge clk7mhz);
        busWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk7mhz);
        busAddr = a; busRead = 1'b1;
        @(posedge clk7mhz);
        #1 d = busDataOut;
        @(negedge clk7mhz);
        busRead = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Expected 72-tick waveform of one byte: 1 -> 6 high of 9, 0 -> 3 high of 9
    function automatic logic [71:0] wave_exp(input logic [7:0] b);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            for (int t = 0; t < 9; t++)
                v[71 - (i*9 + t)] = (t < (b[7-i] ? 6 : 3));
        return v;
    endfunction

    function automatic logic [71:0] wave_obs(input int k, input int c);
        logic [71:0] v;
        for (int j = 0; j < 72; j++) v[71 - j] = cap[k*72 + j][c];
        return v;
    endfunction

    // Record from first high tick until latch, then measure latch length
    task automatic capture(output int n, output int lat, output int dirty);
        int w;
        w = 0;
        while (neoData == 0 && w < 50) begin @(negedge clk7mhz); w++; end
        check("frame_start", w < 50, 1'b1);
        n = 0;
        while (!neoState && n < 4000) begin cap[n] = neoData; n++; @(negedge clk7mhz); end
        lat = 0; dirty = 0;
        while (neoState && lat < 1000) begin
            if (neoData != 0 || !pixelsSync) dirty++;
            lat++;
            @(negedge clk7mhz);
        end
    endtask

    initial begin
        int n, lat, dirty, w, frames;
        logic [7:0] exp3 [6];
        exp3 = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07};

        repeat (3) @(negedge clk7mhz);
        check("rst_neoData", neoData, 4'h0);
        check("rst_neoState", neoState, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_dout", busDataOut, 8'h00);
        resetn = 1'b1;
        read_check("rst_status", 16'h8003, 8'h00);
        read_check("rst_chmask", 16'h8004, 8'h0F);
        read_check("rst_ctrl", 16'h8002, 8'h00);

        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 8; o++)
                bus_write(16'(c*256 + o), 8'h00);

        // Single byte 0xA5 on ch0, limit=1, MAX=0
        bus_write(16'h0000, 8'hA5);
        bus_write(16'h8000, 8'h00);
        bus_write(16'h8001, 8'h00);
        read_check("buf_rd", 16'h0000, 8'hA5);
        bus_write(16'h8002, 8'h06);
        capture(n, lat, dirty);
        check("t1_ticks", n, 72);
        check("t1_ch0", wave_obs(0, 0), wave_exp(8'hA5));
        check("t1_ch1", wave_obs(0, 1), wave_exp(8'h00));
        check("t1_latch", lat, 386);
        check("t1_latch_low", dirty, 0);
        check("t1_irq", irq, 1'b1);
        read_check("t1_status", 16'h8003, 8'h04);
        read_check("t1_ctrl", 16'h8002, 8'h02);

        read_check("unmapped_reg", 16'h8006, 8'h00);
        bus_write(16'h0400, 8'h77);
        read_check("bad_chan", 16'h0400, 8'h00);
        read_check("no_alias", 16'h0000, 8'hA5);
        bus_write(16'h8005, 8'h01);
        check("irqclr", irq, 1'b0);
        read_check("irqclr_status", 16'h8003, 8'h00);

        // Lockstep channels with CHMASK=0x5
        bus_write(16'h0000, 8'h3C);
        bus_write(16'h0100, 8'hFF);
        bus_write(16'h0200, 8'h81);
        bus_write(16'h0300, 8'hFF);
        bus_write(16'h8004, 8'h05);
        bus_write(16'h8002, 8'h06);
        capture(n, lat, dirty);
        check("t2_ticks", n, 72);
        check("t2_ch0", wave_obs(0, 0), wave_exp(8'h3C));
        check("t2_ch1_masked", wave_obs(0, 1), 72'h0);
        check("t2_ch2", wave_obs(0, 2), wave_exp(8'h81));
        check("t2_ch3_masked", wave_obs(0, 3), 72'h0);
        check("t2_latch", lat, 386);
        bus_write(16'h8005, 8'h01);

        // 32-bit mode skips offsets 3 and 7
        bus_write(16'h8004, 8'h01);
        bus_write(16'h0000, 8'h01); bus_write(16'h0001, 8'h02);
        bus_write(16'h0002, 8'h03); bus_write(16'h0003, 8'hEE);
        bus_write(16'h0004, 8'h05); bus_write(16'h0005, 8'h06);
        bus_write(16'h0006, 8'h07); bus_write(16'h0007, 8'h08);
        bus_write(16'h8000, 8'h07);
        bus_write(16'h8002, 8'h16);
        capture(n, lat, dirty);
        check("t3_ticks", n, 432);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_byte%0d", k), wave_obs(k, 0), wave_exp(exp3[k]));
        check("t3_latch", lat, 386);
        read_check("t3_ctrl", 16'h8002, 8'h12);
        bus_write(16'h8005, 8'h01);

        // Loop three frames, then abort mid-frame
        bus_write(16'h8000, 8'h00);
        bus_write(16'h8002, 8'h0E);
        frames = 0;
        for (int f = 0; f < 3; f++) begin
            w = 0;
            while (!neoState && w < 1000) begin @(negedge clk7mhz); w++; end
            while (neoState && w < 2000) begin @(negedge clk7mhz); w++; end
            if (w < 1000 + 386 && !neoState) frames++;
        end
        check("t4_frames", frames, 3);
        w = 0;
        while (neoData[0] == 1'b0 && w < 50) begin @(negedge clk7mhz); w++; end
        check("t4_restart", w < 50, 1'b1);
        repeat (20) @(negedge clk7mhz);
        bus_write(16'h8002, 8'h00);
        check("t4_not_yet", neoState, 1'b0);
        @(negedge clk7mhz);
        check("t4_abort_state", neoState, 1'b1);
        check("t4_abort_data", neoData, 4'h0);
        lat = 0;
        while (neoState && lat < 1000) begin lat++; @(negedge clk7mhz); end
        check("t4_latch", lat, 386);
        check("t4_irq", irq, 1'b0);
        read_check("t4_status", 16'h8003, 8'h00);

        // init strobe mid-bit
        bus_write(16'h0000, 8'hFF);
        bus_write(16'h8002, 8'h06);
        w = 0;
        while (neoData[0] == 1'b0 && w < 50) begin @(negedge clk7mhz); w++; end
        repeat (2) @(negedge clk7mhz);
        check("t5_high", neoData[0], 1'b1);
        bus_write(16'h8002, 8'h07);
        check("t5_init_data", neoData, 4'h0);
        check("t5_init_state", neoState, 1'b0);
        read_check("t5_ctrl", 16'h8002, 8'h00);
        read_check("t5_status", 16'h8003, 8'h00);

        // Reset mid-bit
        bus_write(16'h8002, 8'h06);
        w = 0;
        while (neoData[0] == 1'b0 && w < 50) begin @(negedge clk7mhz); w++; end
        @(negedge clk7mhz);
        check("t6_high", neoData[0], 1'b1);
        resetn = 1'b0;
        @(negedge clk7mhz);
        check("t6_rst_data", neoData, 4'h0);
        check("t6_rst_state", neoState, 1'b0);
        resetn = 1'b1;
        read_check("t6_status", 16'h8003, 8'h00);
        read_check("t6_chmask", 16'h8004, 8'h0F);
        read_check("t6_ctrl", 16'h8002, 8'h00);
        read_check("t6_buf0", 16'h0000, 8'hFF);
        read_check("t6_buf2", 16'h0200, 8'h81);
        read_check("t6_buf5", 16'h0005, 8'h06);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
